// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and 8N1 frame constants,
// usable by both the receive and transmit sides.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned DATA_BITS          = 8;
  localparam logic        STOP_LEVEL         = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops
// reset to the idle (high) level so a reset never fakes a start bit.
module uart_rx_sync (
  input  logic baudclk,
  input  logic reset,
  input  logic rx_async,
  output logic rx_sync
);

  logic meta;

  always_ff @(posedge baudclk) begin
    if (!reset) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      meta    <= rx_async;
      rx_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver with acknowledge handshake and sticky
// framing-error / overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       baudclk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       RX_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_ERR,
  output logic       RX_OVR
);

  localparam int unsigned       TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_e            state, state_next;
  logic                   rx_s;
  logic [TICK_W-1:0]      tick;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   tick_clr, bit_clr, sample_bit, complete, frame_err;

  uart_rx_sync u_sync (
    .baudclk  (baudclk),
    .reset    (reset),
    .rx_async (UART_RX),
    .rx_sync  (rx_s)
  );

  always_ff @(posedge baudclk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (tick == TICK_MID) state_next = rx_s ? IDLE : DATA;
      DATA:      if (tick == TICK_LAST && bit_idx == BIT_LAST) state_next = STOP;
      STOP:      if (tick == TICK_LAST) state_next = (rx_s == STOP_LEVEL) ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Every sample point also restarts the tick count, so non-power-of-two
  // OVERSAMPLE values wrap correctly.
  always_comb begin
    tick_clr   = 1'b0;
    bit_clr    = 1'b0;
    sample_bit = 1'b0;
    complete   = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      IDLE:      tick_clr = 1'b1;
      START: if (tick == TICK_MID) begin
        tick_clr = 1'b1;
        bit_clr  = 1'b1;
      end
      DATA: if (tick == TICK_LAST) begin
        tick_clr   = 1'b1;
        sample_bit = 1'b1;
      end
      STOP: if (tick == TICK_LAST) begin
        tick_clr  = 1'b1;
        complete  = (rx_s == STOP_LEVEL);
        frame_err = (rx_s != STOP_LEVEL);
      end
      WAIT_IDLE: tick_clr = 1'b1;
      default:   tick_clr = 1'b1;
    endcase
  end

  always_ff @(posedge baudclk) begin
    if (!reset) begin
      tick    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      tick <= tick_clr ? '0 : tick + TICK_W'(1);
      if (bit_clr) begin
        bit_idx <= '0;
      end else if (sample_bit) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
    end
  end

  // Priority: framing error, then completion, then a bare acknowledge.
  always_ff @(posedge baudclk) begin
    if (!reset) begin
      RX_DATA   <= '0;
      RX_STATUS <= 1'b0;
      RX_ERR    <= 1'b0;
      RX_OVR    <= 1'b0;
    end else if (frame_err) begin
      RX_ERR <= 1'b1;
      if (RX_ACK) begin
        RX_STATUS <= 1'b0;
        RX_OVR    <= 1'b0;
      end
    end else if (complete) begin
      if (RX_STATUS && !RX_ACK) begin
        RX_OVR <= 1'b1;
      end else begin
        RX_DATA   <= shift;
        RX_STATUS <= 1'b1;
        if (RX_ACK) begin
          RX_ERR <= 1'b0;
          RX_OVR <= 1'b0;
        end
      end
    end else if (RX_ACK) begin
      RX_STATUS <= 1'b0;
      RX_ERR    <= 1'b0;
      RX_OVR    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus randomized traffic, checked
// every cycle against a frame-timing model of the receiver.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int unsigned OS = 16;

  logic       baudclk = 1'b0;
  logic       reset   = 1'b0;
  logic       UART_RX = 1'b1;
  logic       RX_ACK  = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_STATUS, RX_ERR, RX_OVR;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .baudclk   (baudclk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .RX_ACK    (RX_ACK),
    .RX_DATA   (RX_DATA),
    .RX_STATUS (RX_STATUS),
    .RX_ERR    (RX_ERR),
    .RX_OVR    (RX_OVR)
  );

  always #5 baudclk = ~baudclk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  int unsigned ack_mode = 0;   // 0 none, 1 auto, 2 random, 3 forced high
  int unsigned fall_cyc = 0, rise_cyc = 0, stat_fall_cyc = 0;
  int unsigned rise_cnt = 0, err_rise = 0;
  logic        prev_s = 1'b0, prev_e = 1'b0;
  logic [7:0]  got_q[$];

  // Model: frame events are timestamped from the edge where the line, two
  // edges delayed, is first seen low while idle.
  logic        d1 = 1'b1, d2 = 1'b1, m_rxs, m_comp, m_ferr;
  int unsigned m_busy = 0, m_t0 = 0, m_d, m_idx;
  logic [7:0]  m_byte = '0, m_data = '0;
  logic        m_status = 1'b0, m_err = 1'b0, m_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge baudclk);
    cyc++;
    if (!reset) begin
      d1 = 1'b1; d2 = 1'b1; m_busy = 0;
      m_data = '0; m_status = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    end else begin
      m_rxs = d2; d2 = d1; d1 = UART_RX;
      m_comp = 1'b0; m_ferr = 1'b0;
      if (m_busy == 0) begin
        if (!m_rxs) begin m_busy = 1; m_t0 = cyc; end
      end else if (m_busy == 1) begin
        m_d = cyc - m_t0;
        if (m_d == OS / 2) begin
          if (m_rxs) m_busy = 0;
        end else if (m_d > OS / 2 && (m_d - OS / 2) % OS == 0) begin
          m_idx = (m_d - OS / 2) / OS - 1;
          if (m_idx < 8) m_byte[m_idx] = m_rxs;
          else if (m_rxs) begin m_comp = 1'b1; m_busy = 0; end
          else begin m_ferr = 1'b1; m_busy = 2; end
        end
      end else if (m_rxs) begin
        m_busy = 0;
      end
      if (m_ferr) begin
        m_err = 1'b1;
        if (RX_ACK) begin m_status = 1'b0; m_ovr = 1'b0; end
      end else if (m_comp) begin
        if (m_status && !RX_ACK) m_ovr = 1'b1;
        else begin
          m_data = m_byte; m_status = 1'b1;
          if (RX_ACK) begin m_err = 1'b0; m_ovr = 1'b0; end
        end
      end else if (RX_ACK) begin
        m_status = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
      end
    end
  end

  initial begin
    @(posedge baudclk);
    forever begin
      @(negedge baudclk);
      check("cycle {data,status,err,ovr}", {RX_DATA, RX_STATUS, RX_ERR, RX_OVR},
            {m_data, m_status, m_err, m_ovr});
      if (RX_STATUS && !prev_s) begin rise_cnt++; rise_cyc = cyc; got_q.push_back(RX_DATA); end
      if (!RX_STATUS && prev_s) stat_fall_cyc = cyc;
      if (RX_ERR && !prev_e) err_rise++;
      prev_s = RX_STATUS;
      prev_e = RX_ERR;
    end
  end

  initial forever begin
    @(negedge baudclk);
    case (ack_mode)
      1:       RX_ACK = RX_STATUS && !RX_ACK;
      2:       RX_ACK = ($urandom % 4) == 0;
      3:       RX_ACK = 1'b1;
      default: RX_ACK = 1'b0;
    endcase
  end

  task automatic set_ack(input int unsigned m);
    @(posedge baudclk); ack_mode = m; @(negedge baudclk);
  endtask

  task automatic ack_pulse();
    int unsigned saved;
    saved = ack_mode;
    @(posedge baudclk); ack_mode = 3;
    @(posedge baudclk); ack_mode = saved;
    @(negedge baudclk);
  endtask

  task automatic idle(input int unsigned n);
    UART_RX = 1'b1;
    repeat (n) @(negedge baudclk);
  endtask

  task automatic drive_bit(input logic v);
    UART_RX = v;
    repeat (OS) @(negedge baudclk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int unsigned nbits);
    UART_RX  = 1'b0;
    fall_cyc = cyc;
    repeat (OS) @(negedge baudclk);
    for (int unsigned i = 0; i < nbits; i++) drive_bit(b[i]);
    if (nbits == 8) drive_bit(stop_lvl);
  endtask

  int unsigned r0, e0, n0;
  logic [7:0]  rb;
  logic        rstop;

  initial begin
    repeat (3) @(negedge baudclk);
    check("reset outputs", {RX_DATA, RX_STATUS, RX_ERR, RX_OVR}, 32'h0);
    check("reset state", 32'(dut.state), 32'(IDLE));
    reset = 1'b1;
    @(negedge baudclk);

    // 0x55, auto-acknowledged
    set_ack(1);
    send_frame(8'h55, 1'b1, 8);
    idle(2 * OS);
    check("55 data", RX_DATA, 8'h55);
    check("55 model data", m_data, 8'h55);
    check("55 flags", {RX_STATUS, RX_ERR, RX_OVR}, 3'b000);
    check("55 status latency", rise_cyc - fall_cyc, 155);
    check("55 status width", stat_fall_cyc - rise_cyc, 1);

    // back-to-back 0xA5, 0x3C
    r0 = rise_cnt; n0 = got_q.size();
    send_frame(8'hA5, 1'b1, 8);
    send_frame(8'h3C, 1'b1, 8);
    idle(2 * OS);
    check("b2b completions", rise_cnt - r0, 2);
    check("b2b first", got_q[n0], 8'hA5);
    check("b2b second", got_q[n0 + 1], 8'h3C);
    check("b2b model data", m_data, 8'h3C);

    // 4-tick glitch on idle line
    r0 = rise_cnt;
    UART_RX = 1'b0;
    repeat (4) @(negedge baudclk);
    idle(2 * OS);
    check("glitch state", 32'(dut.state), 32'(IDLE));
    check("glitch status", {RX_STATUS, RX_ERR}, 2'b00);
    check("glitch no completion", rise_cnt - r0, 0);

    // framing error then stuck-low line
    set_ack(0);
    e0 = err_rise;
    send_frame(8'hF0, 1'b0, 8);
    UART_RX = 1'b0;
    repeat (40) @(negedge baudclk);
    idle(2 * OS);
    check("ferr count", err_rise - e0, 1);
    check("ferr flags", {RX_STATUS, RX_ERR, RX_OVR}, 3'b010);
    check("ferr model err", m_err, 1'b1);
    send_frame(8'h0F, 1'b1, 8);
    idle(2 * OS);
    check("0F data", RX_DATA, 8'h0F);
    check("0F status", RX_STATUS, 1'b1);
    ack_pulse();
    check("ferr cleared", {RX_STATUS, RX_ERR, RX_OVR}, 3'b000);

    // overrun: 0x11 then 0x22 with no acknowledge
    send_frame(8'h11, 1'b1, 8);
    send_frame(8'h22, 1'b1, 8);
    idle(2 * OS);
    check("ovr data", RX_DATA, 8'h11);
    check("ovr flags", {RX_STATUS, RX_ERR, RX_OVR}, 3'b101);
    check("ovr model", {m_data, m_ovr}, {8'h11, 1'b1});
    ack_pulse();
    check("ovr cleared", {RX_STATUS, RX_ERR, RX_OVR}, 3'b000);

    // reset during bit 3 of 0x99, with a held byte pending
    send_frame(8'h5A, 1'b1, 8);
    idle(2 * OS);
    check("pre-reset status", {RX_DATA, RX_STATUS}, {8'h5A, 1'b1});
    send_frame(8'h99, 1'b1, 3);
    UART_RX = 1'b1;
    repeat (OS / 2) @(negedge baudclk);
    reset = 1'b0;
    repeat (2) @(negedge baudclk);
    reset = 1'b1;
    idle(3 * OS);
    check("mid-frame reset outputs", {RX_DATA, RX_STATUS, RX_ERR, RX_OVR}, 32'h0);
    check("mid-frame reset state", 32'(dut.state), 32'(IDLE));
    set_ack(1);
    send_frame(8'h77, 1'b1, 8);
    idle(2 * OS);
    check("77 data", RX_DATA, 8'h77);
    check("77 last received", got_q[got_q.size() - 1], 8'h77);
    check("77 flags", {RX_ERR, RX_OVR}, 2'b00);

    // randomized traffic: bytes, bad stops, glitches, gaps, random acks
    set_ack(2);
    for (int unsigned k = 0; k < 40; k++) begin
      if ($urandom % 10 == 0) begin
        UART_RX = 1'b0;
        repeat (1 + $urandom % 6) @(negedge baudclk);
        idle(OS);
      end else begin
        rb    = 8'($urandom);
        rstop = ($urandom % 8) != 0;
        send_frame(rb, rstop, 8);
        if (!rstop) begin
          UART_RX = 1'b0;
          repeat ($urandom % 30) @(negedge baudclk);
          idle(OS);
        end
      end
      idle($urandom % 20);
    end
    set_ack(0);
    idle(4 * OS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
